// File: rtl/sort_frame_sequencer.sv
// sort_frame_sequencer
//   Frames one bubble-sort pass over shared memory. It loads N words from the
//   input stream into addresses 0..N-1, hands the memory to the sort
//   controller with a one-cycle start pulse and waits for its done. It then
//   takes the memory back and streams the sorted words out in address order.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   in_valid/in_ready/in_data   input word stream
//   mem_grant                0: this block owns memory, 1: sort controller owns it
//   mem_addr/mem_wdata       memory address / write data
//   mem_write/mem_read       memory requests, held until mem_rdy
//   mem_rdata/mem_rdy        read data / request completion
//   sort_start/sort_done     sort controller handshake
//   out_valid/out_ready/out_data/out_last   sorted word stream
//   busy                     high whenever the sequencer is not IDLE
//
// State  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for the first word of a frame
// ACCEPT | waiting for the next word of a partially loaded frame
// WR     | writing the captured word to mem[index]
// START  | memory handed to sort controller, start pulse
// SORT   | waiting for sort_done
// RD     | reading mem[index]
// OUT    | presenting the read word downstream

module sort_frame_sequencer #(
  parameter int DATA_W = 8,
  parameter int N      = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              mem_grant,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rdy,
  output logic              sort_start,
  input  logic              sort_done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);
  localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_WR,
    S_START,
    S_SORT,
    S_RD,
    S_OUT
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   odata_q, odata_d;
  logic                olast_q, olast_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      wdata_q <= '0;
      odata_q <= '0;
      olast_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      odata_q <= odata_d;
      olast_q <= olast_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    odata_d    = odata_q;
    olast_d    = olast_q;
    in_ready   = 1'b0;
    mem_grant  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_write  = 1'b0;
    mem_read   = 1'b0;
    sort_start = 1'b0;
    out_valid  = 1'b0;
    busy       = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        // The register already sits in IDLE while reset is held, so in_ready
        // is qualified by rst to stay low for the whole reset window.
        in_ready = rst;
        idx_d    = '0;
        if (in_valid) begin
          wdata_d = in_data;
          state_d = S_WR;
        end
      end
      S_ACCEPT: begin
        in_ready = rst;
        if (in_valid) begin
          wdata_d = in_data;
          state_d = S_WR;
        end
      end
      S_WR: begin
        mem_write = 1'b1;
        mem_addr  = idx_q;
        mem_wdata = wdata_q;
        if (mem_rdy) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = S_START;
          end else begin
            idx_d   = idx_q + IDX_ONE;
            state_d = S_ACCEPT;
          end
        end
      end
      S_START: begin
        // sort_done is deliberately not looked at here.
        mem_grant  = 1'b1;
        sort_start = 1'b1;
        state_d    = S_SORT;
      end
      S_SORT: begin
        mem_grant = 1'b1;
        if (sort_done) begin
          state_d = S_RD;
        end
      end
      S_RD: begin
        mem_read = 1'b1;
        mem_addr = idx_q;
        if (mem_rdy) begin
          odata_d = mem_rdata;
          olast_d = (idx_q == LAST_IDX);
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (olast_q) begin
            idx_d   = '0;
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + IDX_ONE;
            state_d = S_RD;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  assign out_data = odata_q;
  assign out_last = olast_q;

endmodule

// File: tb/tb_sort_frame_sequencer.sv
`timescale 1ns/1ps
module tb_sort_frame_sequencer;
  localparam int N = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, mem_grant, mem_write, mem_read, sort_start;
  logic       out_valid, out_last, busy;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata, out_data;
  logic [7:0] mem_rdata = 8'hEE;
  logic       mem_rdy = 1'b0;
  logic       out_ready = 1'b1;
  logic       model_done = 1'b0;
  logic       spur_done = 1'b0;
  logic       sort_done;

  assign sort_done = model_done | spur_done;

  always #5 clk = ~clk;

  sort_frame_sequencer #(.DATA_W(8), .N(16), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mem_grant(mem_grant), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_write(mem_write), .mem_read(mem_read), .mem_rdata(mem_rdata),
    .mem_rdy(mem_rdy), .sort_start(sort_start), .sort_done(sort_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy)
  );

  int total = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
  endtask

  // configuration written by the stimulus process, read by the monitor
  int   cfg_stall = 0;
  int   cfg_bp_abs = -1;
  int   cfg_bp_len = 0;
  int   cfg_sort_delay = 0;
  logic cfg_early = 1'b0;

  // memory / sort-controller / sink model and monitor state
  logic [7:0] mem [16];
  logic [7:0] sw_tmp;
  logic [3:0] wr_addr_q[$];
  logic [7:0] wr_data_q[$];
  logic [3:0] rd_addr_q[$];
  logic [7:0] out_q[$];
  logic       last_q[$];
  int cyc = 0, req_hold = 0, n_start = 0, start_cyc = 0, lastwr_cyc = 0;
  int viol_rw = 0, viol_grant = 0, viol_inrdy = 0, viol_hold = 0, viol_bp = 0;
  int rd_early = 0, bp_cycles = 0, sort_cnt = 0, bp_cnt = 0;
  logic       sort_pend = 1'b0, p_stall = 1'b0, p_wr = 1'b0, p_olast = 1'b0;
  logic [3:0] p_addr = '0;
  logic [7:0] p_wdata = '0, p_odata = '0;

  always @(negedge clk) begin
    cyc++;
    model_done = 1'b0;
    mem_rdy = 1'b0;
    mem_rdata = 8'hEE;
    out_ready = 1'b1;
    if (!rst) begin
      req_hold = 0; sort_pend = 1'b0; p_stall = 1'b0; bp_cnt = 0;
    end else begin
      if (mem_write && mem_read) viol_rw++;
      if (mem_grant && (mem_write || mem_read)) viol_grant++;
      if (in_ready && (mem_write || mem_read || mem_grant || out_valid)) viol_inrdy++;
      if (mem_read && sort_pend) rd_early++;
      if (mem_write || mem_read) begin
        if (req_hold > 0 && (mem_addr !== p_addr || mem_wdata !== p_wdata || mem_write !== p_wr))
          viol_hold++;
        req_hold++;
        p_addr = mem_addr; p_wdata = mem_wdata; p_wr = mem_write;
        if (req_hold == cfg_stall + 1) begin
          mem_rdy = 1'b1;
          req_hold = 0;
          if (mem_write) begin
            mem[mem_addr] = mem_wdata;
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
            lastwr_cyc = cyc;
          end else begin
            mem_rdata = mem[mem_addr];
            rd_addr_q.push_back(mem_addr);
          end
        end
      end else begin
        if (req_hold != 0) viol_hold++;
        req_hold = 0;
      end

      if (sort_start) begin
        n_start++;
        start_cyc = cyc;
        if (!mem_grant) viol_grant++;
        sort_pend = 1'b1;
        sort_cnt = cfg_sort_delay;
        if (cfg_early) model_done = 1'b1;
      end else if (sort_pend) begin
        if (sort_cnt == 0) begin
          for (int i = 0; i < N - 1; i++)
            for (int j = 0; j < N - 1 - i; j++)
              if (mem[j] > mem[j+1]) begin
                sw_tmp = mem[j]; mem[j] = mem[j+1]; mem[j+1] = sw_tmp;
              end
          model_done = 1'b1;
          sort_pend = 1'b0;
        end else begin
          sort_cnt--;
        end
      end

      if (out_valid) begin
        if (out_q.size() == cfg_bp_abs && bp_cnt < cfg_bp_len) begin
          out_ready = 1'b0; bp_cnt++; bp_cycles++;
        end
        if (p_stall && (out_data !== p_odata || out_last !== p_olast)) viol_bp++;
        if (!out_ready && mem_read) viol_bp++;
        if (out_ready) begin
          out_q.push_back(out_data);
          last_q.push_back(out_last);
          bp_cnt = 0; p_stall = 1'b0;
        end else begin
          p_stall = 1'b1; p_odata = out_data; p_olast = out_last;
        end
      end else begin
        if (p_stall) viol_bp++;
        p_stall = 1'b0;
      end
    end
  end

  typedef struct {
    int         stall;
    int         gap;
    int         bp_word;
    int         bp_len;
    int         sort_delay;
    logic       early;
    logic       spur;
    logic [7:0] seed;
    logic [7:0] step;
    logic [7:0] exp_min;
    logic [7:0] exp_max;
  } vec_t;

  vec_t vecs[5];

  // Enter and leave at a falling edge.
  task automatic push(input logic [7:0] d, input int gap);
    int g;
    g = 0;
    while (!in_ready && g < 100) begin @(negedge clk); g++; end
    chk("in_ready_wait", in_ready, 1);
    for (int k = 0; k < gap; k++) begin
      chk("gap_in_ready", in_ready, 1);
      chk("gap_no_write", mem_write, 0);
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data = 8'h00;
    @(negedge clk);
  endtask

  task automatic run_frame(input vec_t v);
    int wb, rb, ob, sb, bpb, g;
    logic [7:0] d[16];
    logic [7:0] e[16];
    logic [7:0] t;
    cfg_stall = v.stall;
    cfg_bp_len = v.bp_len;
    cfg_sort_delay = v.sort_delay;
    cfg_early = v.early;
    wb = wr_addr_q.size(); rb = rd_addr_q.size(); ob = out_q.size();
    sb = n_start; bpb = bp_cycles;
    cfg_bp_abs = ob + v.bp_word;
    for (int i = 0; i < N; i++) d[i] = v.seed + 8'(i) * v.step;
    // insertion sort for the expected order
    for (int i = 0; i < N; i++) begin
      e[i] = d[i];
      for (int j = i; j > 0; j--)
        if (e[j-1] > e[j]) begin t = e[j]; e[j] = e[j-1]; e[j-1] = t; end
    end
    for (int i = 0; i < N; i++) begin
      spur_done = v.spur && (i < 8);
      push(d[i], (i == 0) ? 0 : v.gap);
      if (v.spur && i < 8) begin
        chk("spur_grant", mem_grant, 0);
        chk("spur_no_start", n_start - sb, 0);
      end
    end
    spur_done = 1'b0;
    g = 0;
    while (out_q.size() < ob + N && g < 3000) begin @(negedge clk); g++; end
    chk("frame_done", out_q.size() >= ob + N, 1);
    chk("wr_count", wr_addr_q.size() - wb, N);
    chk("rd_count", rd_addr_q.size() - rb, N);
    if (out_q.size() >= ob + N && wr_addr_q.size() >= wb + N && rd_addr_q.size() >= rb + N) begin
      for (int i = 0; i < N; i++) begin
        chk("wr_addr", wr_addr_q[wb+i], i);
        chk("wr_data", wr_data_q[wb+i], d[i]);
        chk("rd_addr", rd_addr_q[rb+i], i);
        chk("out_data", out_q[ob+i], e[i]);
        chk("out_last", last_q[ob+i], (i == N - 1));
      end
      chk("first_word", out_q[ob], v.exp_min);
      chk("last_word", out_q[ob+N-1], v.exp_max);
    end
    chk("start_pulses", n_start - sb, 1);
    chk("start_latency", start_cyc - lastwr_cyc, 1);
    chk("bp_cycles", bp_cycles - bpb, (v.bp_word < N) ? v.bp_len : 0);
    chk("rw_exclusive", viol_rw, 0);
    chk("grant_no_req", viol_grant, 0);
    chk("in_ready_busy", viol_inrdy, 0);
    chk("req_hold", viol_hold, 0);
    chk("bp_stable", viol_bp, 0);
    chk("read_before_done", rd_early, 0);
    repeat (2) @(negedge clk);
    chk("end_busy", busy, 0);
    chk("end_in_ready", in_ready, 1);
    cfg_bp_abs = -1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_mem_grant"}, mem_grant, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_mem_write"}, mem_write, 0);
    chk({tag, "_mem_read"}, mem_read, 0);
    chk({tag, "_sort_start"}, sort_start, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_last"}, out_last, 0);
  endtask

  initial begin
    int g;
    vecs[0] = '{stall:0, gap:0, bp_word:99, bp_len:0, sort_delay:0, early:1'b0, spur:1'b0,
                seed:8'h0F, step:8'hFF, exp_min:8'h00, exp_max:8'h0F};
    vecs[1] = '{stall:3, gap:0, bp_word:99, bp_len:0, sort_delay:1, early:1'b0, spur:1'b0,
                seed:8'h20, step:8'h03, exp_min:8'h20, exp_max:8'h4D};
    vecs[2] = '{stall:0, gap:0, bp_word:3, bp_len:5, sort_delay:2, early:1'b0, spur:1'b0,
                seed:8'hF0, step:8'h11, exp_min:8'h01, exp_max:8'hF0};
    vecs[3] = '{stall:0, gap:2, bp_word:99, bp_len:0, sort_delay:4, early:1'b1, spur:1'b0,
                seed:8'h80, step:8'hF9, exp_min:8'h17, exp_max:8'h80};
    vecs[4] = '{stall:1, gap:1, bp_word:15, bp_len:2, sort_delay:3, early:1'b0, spur:1'b1,
                seed:8'h5A, step:8'h00, exp_min:8'h5A, exp_max:8'h5A};

    rst = 1'b0;
    #1;
    chk_reset_outputs("por");
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("post_reset_in_ready", in_ready, 1);

    // sort_done while idle must not start anything
    spur_done = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("idle_done_busy", busy, 0);
      chk("idle_done_grant", mem_grant, 0);
    end
    spur_done = 1'b0;
    chk("idle_done_starts", n_start, 0);
    @(negedge clk);

    for (int v = 0; v < 5; v++) run_frame(vecs[v]);

    // reset while the sort controller owns the memory
    cfg_stall = 0; cfg_sort_delay = 30; cfg_early = 1'b0; cfg_bp_abs = -1;
    for (int i = 0; i < N; i++) push(8'(i * 5 + 1), 0);
    g = 0;
    while (!(mem_grant && !sort_start) && g < 50) begin @(negedge clk); g++; end
    chk("reached_sort_grant", mem_grant, 1);
    chk("reached_sort_busy", busy, 1);
    #2 rst = 1'b0;
    #1;
    chk_reset_outputs("midsort");
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("release_busy", busy, 0);
    chk("release_grant", mem_grant, 0);
    chk("release_in_ready", in_ready, 1);
    @(negedge clk);
    chk("release_idle_busy", busy, 0);
    run_frame(vecs[0]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sort_frame_sequencer.md
Name: sort_frame_sequencer

Overview:
- Frames the bubble-sort engine: accepts N words on a valid/ready input stream and writes them into the shared sort memory at addresses 0..N-1.
- Hands the memory to the sort controller and pulses its start input, then waits for its done.
- Reclaims the memory and streams the sorted words out in address order on a valid/ready output stream.
- Sits directly upstream of the sort controller (feeds its memory and start) and also drains what it produces.

Parameters:
- DATA_W, 8, data word width.
- N, 16, words per frame (2..2^ADDR_W).
- ADDR_W, 4, memory address width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  input word available.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  DATA_W  input word.
- mem_grant  output  1  0 = this block drives memory; 1 = sort controller drives memory (external mux select).
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_write  output  1  write request.
- mem_read  output  1  read request.
- mem_rdata  input  DATA_W  memory read data, valid when mem_rdy=1 during a read.
- mem_rdy  input  1  memory completes the current request this cycle.
- sort_start  output  1  one-cycle start pulse to the sort controller.
- sort_done  input  1  sort controller finished.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  DATA_W  sorted word.
- out_last  output  1  marks word N-1 of the frame.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE; index counter = 0.
  - All outputs 0: in_ready, mem_grant, mem_addr, mem_wdata, mem_write, mem_read, sort_start, out_valid, out_data, out_last, busy.
- States and transitions:
  - IDLE: in_ready=1. On in_valid&in_ready, latch in_data into the write register and go to WR. Index = 0.
  - ACCEPT: in_ready=1. Same capture, then WR.
  - WR:
    - Drive mem_write=1, mem_addr=index, mem_wdata=latched word; hold all three stable until mem_rdy=1.
    - On the mem_rdy cycle the write completes.
    - If index==N-1, go to START with index reset to 0; else index+1 and go to ACCEPT.
    - in_ready=0 in WR.
  - START: mem_grant=1, sort_start=1 for exactly this one cycle, then SORT.
  - SORT:
    - mem_grant=1; all memory outputs from this block are 0.
    - On sort_done=1, go to RD with mem_grant=0 from the next cycle.
  - RD:
    - mem_read=1, mem_addr=index, held until mem_rdy=1.
    - On that edge capture mem_rdata into out_data and set out_last=(index==N-1). Go to OUT.
  - OUT:
    - out_valid=1; out_data and out_last held stable until out_ready=1.
    - On the handshake: if out_last, go to IDLE with index=0; else index+1 and go to RD.
    - out_valid drops in the following cycle.
- Latency with mem_rdy tied high:
  - Input handshake at edge t, write completes at t+1, in_ready high again at t+2 (2 cycles per word).
  - Last write completes at edge w; sort_start is high in cycle w+1.
  - sort_done sampled at edge d; mem_read asserted cycle d+1; out_valid asserted cycle d+2.
- Boundary rules:
  - mem_write and mem_read are never high together.
  - Neither is high while mem_grant=1.
  - in_ready=0 from START through the final output handshake, so a new frame is never accepted during a sort or drain.
  - sort_done outside SORT is ignored; it must not cause a state change.
  - sort_done arriving in the same cycle as START is ignored; only SORT samples it.
  - in_valid deasserting mid-frame stalls in ACCEPT indefinitely; the partial frame is kept.
  - Reset at any point (mid-load, mid-sort, mid-drain) aborts the frame and returns to IDLE with the outputs listed above. Memory contents are not cleared.
  - The index counter is ADDR_W bits and never wraps past N-1.

Test Plan:
- Basic frame: N=16, mem_rdy=1, out_ready=1, in_data 15,14,..,0 -> writes at addr 0..15 with data 15..0; exactly one sort_start pulse one cycle after the addr-15 write; a memory model sorts and raises sort_done -> reads addr 0..15; out_data equals memory contents in order; out_last only on the 16th word.
- Memory stall: mem_rdy low for 3 cycles on every request -> mem_write/mem_addr/mem_wdata held stable 4 cycles per write; mem_read held 4 cycles per read; no data loss.
- Backpressure: out_ready low for 5 cycles on word 3 -> out_valid=1 and out_data constant for 5 cycles; no mem_read issued until the handshake.
- Input gaps: in_valid toggles 1,0,0,1 -> block waits in ACCEPT; the addr sequence has no skips; in_ready=0 in every WR cycle.
- Spurious done: sort_done=1 in IDLE and during load -> no state change, no sort_start, mem_grant stays 0.
- Reset mid-sort: rst=0 for 1 cycle in SORT -> busy=0, mem_grant=0, in_ready=1 after release; a subsequent full frame completes correctly.
